reg_pipe_mux: RTL
=================

REG_PIPE_MUX -- requirements
Module: reg_pipe_mux

Interface
REQ-001 Parameter WIDTH, default 18, data width in bits; SHALL be legal for 1..48.
REQ-002 Parameter DEPTH, default 4, number of stage slots; SHALL be legal for 1..8.
REQ-003 Parameter BYPASS_MASK, default 0 (DEPTH bits); bit i=1 SHALL make slot i combinational (pass-through), bit i=0 SHALL make it a register.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-006 en  input  1  clock enable; 0 SHALL hold every registered slot (data and valid).
REQ-007 flush  input  1  synchronous clear of all slot contents and valids.
REQ-008 in_data  input  WIDTH  stage-0 data input.
REQ-009 in_valid  input  1  qualifies in_data.
REQ-010 out_data  output  WIDTH  last-slot data output.
REQ-011 out_valid  output  1  qualifies out_data.
REQ-012 occupancy  output  4  count of registered slots currently holding valid data.

Function
REQ-013 Latency LAT SHALL equal DEPTH minus popcount(BYPASS_MASK) cycles of en=1, in_data to out_data.
REQ-014 Slot i input SHALL be slot i-1 output (slot 0 input = in_data/in_valid); data and valid SHALL travel together.
REQ-015 Registered slot, en=1, flush=0: SHALL capture upstream data and valid on the clock edge.
REQ-016 Registered slot, en=0: SHALL hold data and valid regardless of upstream changes.
REQ-017 Bypassed slot SHALL forward upstream data and valid combinationally, holding no state.
REQ-018 LAT=0 (all bypassed): out_data=in_data, out_valid=in_valid combinationally, occupancy constant 0.
REQ-019 flush=1 with rst=1: every registered slot's data and valid SHALL clear to 0 on the edge, independent of en.
REQ-020 flush and en both 1: flush SHALL win; in_data presented that cycle SHALL be discarded.
REQ-021 Invalid beats (in_valid=0) SHALL still propagate data; out_valid=0 marks them. Consumers SHALL ignore out_data when out_valid=0.
REQ-022 occupancy SHALL be a registered counter updated on the edge: +1 when a valid enters slot 0's register and none leaves the last register; -1 for the reverse; unchanged when both or neither occur, or en=0.
REQ-023 occupancy SHALL never exceed LAT nor underflow; flush SHALL set it to 0.
REQ-024 occupancy SHALL always equal the number of registered slots with valid=1.

Reset
REQ-025 rst=0 on a clock edge SHALL clear all slot data to 0, all valids to 0 and occupancy to 0, overriding en and flush.
REQ-026 Reset mid-stream SHALL discard in-flight data; the first valid after release SHALL appear at out_valid exactly LAT en-cycles later.
REQ-027 Outputs of registered paths SHALL read out_data=0, out_valid=0, occupancy=0 from the edge after reset until new data arrives.

Structure
REQ-028 Package reg_pipe_pkg SHALL hold the popcount function, the LAT computation, and max-DEPTH/WIDTH constants.
REQ-029 One sub-module pipe_stage (WIDTH, BYPASS parameters; data+valid register with bypass mux, en, flush, rst) SHALL be instantiated DEPTH times via generate.
REQ-030 Parameter range violations SHALL be flagged at elaboration.

Verification
REQ-031 DEPTH=4, mask=0, en=1, in_data=0x00001..0x00005 valid on consecutive cycles -> out_data equals the same values 4 cycles later, out_valid=1; occupancy reaches 4.
REQ-032 DEPTH=4, mask=4'b0101 -> LAT=2; single valid 0x3FFFF -> out_valid for exactly one cycle, 2 cycles after input.
REQ-033 Pipeline full (occupancy=4), en=0 for 3 cycles while in_data changes -> out_data and occupancy frozen; resume -> original sequence continues unbroken.
REQ-034 occupancy=3, flush=1 and en=1 with valid in_data=0x12345 -> next cycle occupancy=0, out_valid=0; 0x12345 never emerges.
REQ-035 rst=0 asserted mid-stream with flush=0, en=1 -> next edge all outputs 0; first post-reset valid emerges exactly LAT cycles later.
REQ-036 mask=all ones (LAT=0) -> out_data/out_valid follow in_data/in_valid in the same cycle; occupancy stays 0 through rst, flush and en toggling.

Source files
------------

// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg
//   Shared constants and helpers for the reg_pipe_mux pipeline:
//   legal parameter ranges, occupancy counter width, a popcount helper
//   and the latency computation (registered slots = DEPTH - bypassed slots).
package reg_pipe_pkg;

   localparam int unsigned MIN_WIDTH = 1;
   localparam int unsigned MAX_WIDTH = 48;
   localparam int unsigned MIN_DEPTH = 1;
   localparam int unsigned MAX_DEPTH = 8;
   localparam int unsigned OCC_W     = 4;

   function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < MAX_DEPTH; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Mask bits above the real depth are zero by construction (zero-extended).
   function automatic int unsigned calc_lat(input int unsigned depth,
                                            input logic [MAX_DEPTH-1:0] mask);
      return depth - popcount(mask);
   endfunction

endpackage

// File: rtl/reg_pipe_mux_pipe_stage.sv
// pipe_stage
//   One pipeline slot: a data+valid register with a bypass mux.
//   BYPASS=1 forwards upstream data/valid combinationally; BYPASS=0
//   presents the registered copy.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   en        clock enable (0 holds data and valid)
//   flush     synchronous clear, wins over en
//   in_data   upstream data    / in_valid  upstream valid
//   out_data  slot data output / out_valid slot valid output
module pipe_stage #(
   parameter int unsigned WIDTH  = 18,
   parameter bit          BYPASS = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid
);

   logic [WIDTH-1:0] data_d, data_q;
   logic             valid_d, valid_q;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (flush) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (en) begin
         data_d  = in_data;
         valid_d = in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   // BYPASS is a constant: a bypassed slot never observes its register.
   assign out_data  = BYPASS ? in_data  : data_q;
   assign out_valid = BYPASS ? in_valid : valid_q;

endmodule

// File: rtl/reg_pipe_mux.sv
// reg_pipe_mux
//   Configurable pipeline of DEPTH slots; each slot is either a register
//   or a combinational pass-through (BYPASS_MASK bit = 1). Latency is
//   DEPTH - popcount(BYPASS_MASK) enabled cycles. A registered counter
//   tracks how many registered slots hold valid data.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   en         clock enable for every registered slot and the counter
//   flush      synchronous clear of all slots and the counter
//   in_data    stage-0 data    / in_valid  stage-0 valid
//   out_data   last-slot data  / out_valid last-slot valid
//   occupancy  number of registered slots holding valid data
module reg_pipe_mux
   import reg_pipe_pkg::*;
#(
   parameter int unsigned          WIDTH       = 18,
   parameter int unsigned          DEPTH       = 4,
   parameter logic [DEPTH-1:0]     BYPASS_MASK = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic [3:0]       occupancy
);

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("reg_pipe_mux: WIDTH=%0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
   end
   if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
      $error("reg_pipe_mux: DEPTH=%0d outside %0d..%0d", DEPTH, MIN_DEPTH, MAX_DEPTH);
   end

   localparam logic [MAX_DEPTH-1:0] MASK_EXT = MAX_DEPTH'(BYPASS_MASK);
   localparam int unsigned          LAT      = calc_lat(DEPTH, MASK_EXT);

   logic [WIDTH-1:0] chain_data  [0:DEPTH];
   logic             chain_valid [0:DEPTH];

   assign chain_data[0]  = in_data;
   assign chain_valid[0] = in_valid;

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      pipe_stage #(
         .WIDTH  (WIDTH),
         .BYPASS (BYPASS_MASK[i])
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .flush     (flush),
         .in_data   (chain_data[i]),
         .in_valid  (chain_valid[i]),
         .out_data  (chain_data[i+1]),
         .out_valid (chain_valid[i+1])
      );
   end

   assign out_data  = chain_data[DEPTH];
   assign out_valid = chain_valid[DEPTH];

   logic [OCC_W-1:0] occupancy_d, occupancy_q;

   // Leading bypass slots forward in_valid straight to the first register,
   // and trailing bypass slots expose the last register's valid on
   // out_valid, so these two signals are the enter/leave events.
   always_comb begin
      occupancy_d = occupancy_q;
      if (LAT == 0) begin
         occupancy_d = '0;
      end else if (flush) begin
         occupancy_d = '0;
      end else if (en) begin
         if (in_valid && !out_valid) begin
            occupancy_d = occupancy_q + 4'd1;
         end else if (!in_valid && out_valid) begin
            occupancy_d = occupancy_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         occupancy_q <= '0;
      end else begin
         occupancy_q <= occupancy_d;
      end
   end

   assign occupancy = occupancy_q;

endmodule
